// File: rtl/ps2_keyboard_rx_fifo.sv
// PS/2 keyboard receiver: synchroniser + clock deglitch, 11-bit frame checker
// with timeout, E0/F0 prefix folding into 10-bit key events, and a
// first-word-fall-through event FIFO with valid/ready pop and sticky overflow.
module ps2_keyboard_rx_fifo #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 8,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  output logic [9:0]    ev_data,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [CW-1:0] fifo_count,
  output logic          overflow,
  input  logic          clr_flags,
  output logic          err_parity,
  output logic          err_frame,
  output logic          err_timeout
);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // ---------------- input conditioning ----------------
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  // Two-flop synchronisers; filtered clock only follows after FILT_LEN equal samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1; clk_s2 <= 1'b1;
      dat_s1 <= 1'b1; dat_s2 <= 1'b1;
      filt <= 1'b1; filt_prev <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_s1 <= ps2_clk;  clk_s2 <= clk_s1;
      dat_s1 <= ps2_data; dat_s2 <= dat_s1;
      filt_prev <= filt;
      if (clk_s2 == filt)
        filt_cnt <= '0;
      else if (filt_cnt == FW'(FILT_LEN - 1)) begin
        filt     <= clk_s2;
        filt_cnt <= '0;
      end else
        filt_cnt <= filt_cnt + FW'(1);
    end
  end

  assign fall = filt_prev & ~filt;

  // ---------------- frame FSM ----------------
  state_t        state, state_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic          par_ok, par_ok_d;
  logic [TW-1:0] tmo, tmo_d;
  logic          ep_d, ef_d, et_d, byte_vld, byte_vld_d;

  // State register plus registered error/accept pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE; bit_idx <= '0; shreg <= '0; par_ok <= 1'b0; tmo <= '0;
      err_parity <= 1'b0; err_frame <= 1'b0; err_timeout <= 1'b0; byte_vld <= 1'b0;
    end else begin
      state <= state_d; bit_idx <= bit_idx_d; shreg <= shreg_d;
      par_ok <= par_ok_d; tmo <= tmo_d;
      err_parity <= ep_d; err_frame <= ef_d; err_timeout <= et_d; byte_vld <= byte_vld_d;
    end
  end

  // Next-state: bits move only on filtered falling edges; timeout runs mid-frame.
  always_comb begin
    state_d = state; bit_idx_d = bit_idx; shreg_d = shreg; par_ok_d = par_ok;
    tmo_d = tmo; ep_d = 1'b0; ef_d = 1'b0; et_d = 1'b0; byte_vld_d = 1'b0;
    if (fall) begin
      tmo_d = '0;
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_d = DATA; bit_idx_d = '0;
          end else
            ef_d = 1'b1;
        end
        DATA: begin
          shreg_d   = {dat_s2, shreg[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_ok_d = ^shreg ^ dat_s2;
          state_d  = STOP;
        end
        default: begin
          state_d = IDLE;
          if (!dat_s2)      ef_d = 1'b1;
          else if (!par_ok) ep_d = 1'b1;
          else              byte_vld_d = 1'b1;
        end
      endcase
    end else if (state != IDLE) begin
      if (tmo == TW'(TIMEOUT_CYC - 1)) begin
        et_d = 1'b1; state_d = IDLE; tmo_d = '0;
      end else
        tmo_d = tmo + TW'(1);
    end else
      tmo_d = '0;
  end

  // ---------------- prefix decode ----------------
  logic       expand, brk, err_any, push;
  logic [9:0] push_data;

  assign err_any   = err_parity | err_frame | err_timeout;
  assign push      = byte_vld && shreg != 8'hE0 && shreg != 8'hF0;
  assign push_data = {expand, brk, shreg};

  // Prefix flags: set by E0/F0, consumed by the next key byte, dropped on any error.
  always_ff @(posedge clk) begin
    if (rst || err_any) begin
      expand <= 1'b0; brk <= 1'b0;
    end else if (byte_vld) begin
      if (shreg == 8'hE0)      expand <= 1'b1;
      else if (shreg == 8'hF0) brk    <= 1'b1;
      else begin
        expand <= 1'b0; brk <= 1'b0;
      end
    end
  end

  // ---------------- event FIFO ----------------
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, full, do_push;

  assign ev_valid = fifo_count != '0;
  assign full     = fifo_count == CW'(FIFO_DEPTH);
  assign pop      = ev_valid & ev_ready;
  assign do_push  = push & (~full | pop);
  assign ev_data  = ev_valid ? mem[rd_ptr] : '0;

  // Storage array; contents are don't-care while empty since ev_data is masked.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and sticky overflow (a new overflow beats clr_flags).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0; rd_ptr <= '0; fifo_count <= '0; overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
      else if (clr_flags)   overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ps2_keyboard_rx_fifo.sv
// Bench for ps2_keyboard_rx_fifo: a frame-level model predicts events, errors
// and overflow; a per-cycle monitor checks every popped event against it.
module tb_ps2_keyboard_rx_fifo;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0, rst, ps2_clk, ps2_data, ev_ready, clr_flags;
  logic [9:0]    ev_data;
  logic          ev_valid, overflow, err_parity, err_frame, err_timeout;
  logic [CW-1:0] fifo_count;

  ps2_keyboard_rx_fifo #(.FILT_LEN(8), .TIMEOUT_CYC(1000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .fifo_count(fifo_count), .overflow(overflow), .clr_flags(clr_flags),
    .err_parity(err_parity), .err_frame(err_frame), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // model state
  logic [9:0] exp_q[$];
  bit m_exp, m_brk, m_ovf;
  int e_par = 0, e_frm = 0, e_tmo = 0;
  // monitor state
  int n_par = 0, n_frm = 0, n_tmo = 0, npop = 0;
  logic [9:0] last_pop = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level model: what one complete frame does to flags/queue/errors.
  task automatic model_frame(input logic [7:0] b, input bit badpar, input bit badstop, input bit pp);
    if (badstop) begin
      e_frm++; m_exp = 0; m_brk = 0;
    end else if (badpar) begin
      e_par++; m_exp = 0; m_brk = 0;
    end else if (b == 8'hE0) m_exp = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (!ev_ready && exp_q.size() >= DEPTH && !pp) m_ovf = 1;
      else exp_q.push_back({m_exp, m_brk, b});
      m_exp = 0; m_brk = 0;
    end
  endtask

  task automatic ps2_bit(input logic b, input bit gl);
    ps2_data = b; wait_cyc(10);
    ps2_clk = 1'b0; wait_cyc(20);
    ps2_clk = 1'b1;
    if (gl) begin
      wait_cyc(6); ps2_clk = 1'b0; wait_cyc(3); ps2_clk = 1'b1; wait_cyc(11);
    end else wait_cyc(20);
  endtask

  // pp: pulse ev_ready exactly in the push cycle (fall + 1) of the stop bit.
  task automatic send_frame(input logic [7:0] b, input bit badpar, input bit badstop,
                            input bit gl, input bit pp);
    logic par;
    par = ~^b;
    if (badpar) par = ~par;
    model_frame(b, badpar, badstop, pp);
    ps2_bit(1'b0, gl);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], gl);
    ps2_bit(par, gl);
    ps2_data = ~badstop; wait_cyc(10);
    ps2_clk = 1'b0;
    if (pp) begin
      wait_cyc(11); ev_ready = 1'b1; wait_cyc(1); ev_ready = 1'b0; wait_cyc(8);
    end else wait_cyc(20);
    ps2_clk = 1'b1; ps2_data = 1'b1; wait_cyc(20);
  endtask

  task automatic send_partial(input int nbits);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(1'b1, 1'b0);
  endtask

  task automatic checkpoint(input string tag);
    wait_cyc(5);
    chk({tag, "_count"}, fifo_count, exp_q.size());
    chk({tag, "_ovf"}, overflow, m_ovf);
    chk({tag, "_npar"}, n_par, e_par);
    chk({tag, "_nfrm"}, n_frm, e_frm);
    chk({tag, "_ntmo"}, n_tmo, e_tmo);
  endtask

  // Per-cycle monitor: pops compared to model head; error pulses counted.
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid_vs_count", ev_valid, fifo_count != 0);
      if (ev_valid && ev_ready) begin
        if (exp_q.size() == 0) chk("unexpected_pop", ev_data, 0 - 1);
        else chk("pop_data", ev_data, exp_q.pop_front());
        last_pop = ev_data;
        npop++;
      end
      if (err_parity)  n_par++;
      if (err_frame)   n_frm++;
      if (err_timeout) n_tmo++;
    end
  end

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ev_ready = 1'b1; clr_flags = 1'b0;
    wait_cyc(5);
    chk("rst_valid", ev_valid, 0); chk("rst_data", ev_data, 0);
    chk("rst_count", fifo_count, 0); chk("rst_ovf", overflow, 0);
    chk("rst_errs", {err_parity, err_frame, err_timeout}, 0);
    rst = 1'b0; wait_cyc(20);

    // single key
    send_frame(8'h1C, 0, 0, 0, 0);
    checkpoint("t1");
    chk("t1_last", last_pop, 10'h01C); chk("t1_npop", npop, 1);

    // extended break then plain make
    send_frame(8'hE0, 0, 0, 0, 0); send_frame(8'hF0, 0, 0, 0, 0); send_frame(8'h75, 0, 0, 0, 0);
    checkpoint("t2a");
    chk("t2_last", last_pop, 10'h375); chk("t2_npop", npop, 2);
    send_frame(8'h75, 0, 0, 0, 0);
    checkpoint("t2b");
    chk("t2b_last", last_pop, 10'h075);

    // parity error then frame error clear the break flag
    send_frame(8'hF0, 0, 0, 0, 0); send_frame(8'h1C, 1, 0, 0, 0); send_frame(8'h1C, 0, 0, 0, 0);
    checkpoint("t3a");
    chk("t3_par", n_par, 1); chk("t3_last", last_pop, 10'h01C); chk("t3_npop", npop, 4);
    send_frame(8'hF0, 0, 0, 0, 0); send_frame(8'h1C, 0, 1, 0, 0); send_frame(8'h1C, 0, 0, 0, 0);
    checkpoint("t3b");
    chk("t3_frm", n_frm, 1); chk("t3b_last", last_pop, 10'h01C); chk("t3b_npop", npop, 5);

    // timeout after start + 4 bits
    e_tmo++; m_exp = 0; m_brk = 0;
    send_partial(4); wait_cyc(1200);
    checkpoint("t4a");
    chk("t4_tmo", n_tmo, 1);
    send_frame(8'h29, 0, 0, 0, 0);
    checkpoint("t4b");
    chk("t4_last", last_pop, 10'h029);

    // glitchy clock
    send_frame(8'h1C, 0, 0, 1, 0);
    checkpoint("t5");
    chk("t5_last", last_pop, 10'h01C); chk("t5_npop", npop, 7);

    // overflow, clear, push+pop at full, drain
    ev_ready = 1'b0;
    send_frame(8'h16, 0, 0, 0, 0); send_frame(8'h1E, 0, 0, 0, 0); send_frame(8'h26, 0, 0, 0, 0);
    send_frame(8'h25, 0, 0, 0, 0); send_frame(8'h2E, 0, 0, 0, 0);
    checkpoint("t6a");
    chk("t6_full", fifo_count, 4); chk("t6_ovf1", overflow, 1);
    clr_flags = 1'b1; wait_cyc(1); clr_flags = 1'b0; m_ovf = 0;
    checkpoint("t6b");
    send_frame(8'h1C, 0, 0, 0, 1);
    checkpoint("t6c");
    chk("t6_pp_count", fifo_count, 4); chk("t6_pp_pop", last_pop, 10'h016);
    ev_ready = 1'b1; wait_cyc(10);
    checkpoint("t6d");
    chk("t6_drain_last", last_pop, 10'h01C); chk("t6_npop", npop, 12);

    // reset mid-frame with a queued event and a pending prefix
    ev_ready = 1'b0;
    send_frame(8'h16, 0, 0, 0, 0); send_frame(8'hE0, 0, 0, 0, 0);
    send_partial(3);
    rst = 1'b1; wait_cyc(2);
    chk("t7_valid", ev_valid, 0); chk("t7_data", ev_data, 0);
    chk("t7_count", fifo_count, 0); chk("t7_ovf", overflow, 0);
    chk("t7_errs", {err_parity, err_frame, err_timeout}, 0);
    exp_q.delete(); m_exp = 0; m_brk = 0; m_ovf = 0;
    rst = 1'b0; ev_ready = 1'b1; wait_cyc(20);
    send_frame(8'h1C, 0, 0, 0, 0);
    checkpoint("t7b");
    chk("t7_last", last_pop, 10'h01C); chk("t7_npop", npop, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_keyboard_rx_fifo.md
Name: ps2_keyboard_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver. It deglitches the PS/2 clock and checks the full 11-bit frame: start bit, odd parity, stop bit and an inter-bit timeout. It folds the E0 (extended) and F0 (break) prefixes into 10-bit key events and buffers the events in a FIFO with a valid/ready handshake. It sits between the board PS/2 pins and game-control logic, and it adds error reporting and event buffering.

Parameters:
FILT_LEN, 8, number of consecutive identical synchronised samples required before the filtered PS/2 clock changes (min 2).
TIMEOUT_CYC, 100000, number of clk cycles without a filtered falling edge, while mid-frame, that aborts the frame.
FIFO_DEPTH, 8, number of event entries; must be a power of 2, at least 2.
CW (localparam), $clog2(FIFO_DEPTH)+1, width of fifo_count.

Ports:
clk  in  1  system clock (only clock)
rst  in  1  synchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
ev_data  out  10  head event {expand, break, scancode[7:0]}
ev_valid  out  1  FIFO not empty; ev_data valid
ev_ready  in  1  consumer pops the head when ev_valid && ev_ready
fifo_count  out  CW  current number of FIFO entries
overflow  out  1  sticky; an event was dropped because the FIFO was full
clr_flags  in  1  clears overflow
err_parity  out  1  1-cycle pulse on a parity error
err_frame  out  1  1-cycle pulse on a bad start bit or bad stop bit
err_timeout  out  1  1-cycle pulse on a frame timeout

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) clears everything, including mid-frame state: sync/filter registers to 1 (idle high), bit counter 0, prefix flags 0, FIFO empty. Output reset values: ev_valid=0, ev_data=0, fifo_count=0, overflow=0, all err_* = 0.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - The filtered clock takes the synchronised clock value only after FILT_LEN consecutive equal samples.
  - fall = filtered clock goes 1 to 0; it is asserted for exactly one cycle per falling edge.
- Frame FSM states: IDLE, DATA, PARITY, STOP. All transitions happen on fall cycles; the synchronised ps2_data is sampled in that same cycle.
  - IDLE: data=0 moves to DATA with bit index 0. data=1 pulses err_frame and stays in IDLE.
  - DATA: shifts bits in LSB first. After the 8th bit, moves to PARITY.
  - PARITY: records parity_ok = (^byte ^ data) == 1 (odd parity). Moves to STOP.
  - STOP:
    - data=1 and parity_ok: byte accepted.
    - data=1 and not parity_ok: err_parity.
    - data=0: err_frame (takes priority over a parity error).
    - Always returns to IDLE.
- Timeout: a counter resets on every fall and counts only while the FSM is not IDLE. When it reaches TIMEOUT_CYC: err_timeout pulses, the FSM goes to IDLE, and the partial byte is discarded.
- Any error (parity, frame or timeout) also clears the expand and break flags.
- Decode of an accepted byte (acts in the cycle after the STOP fall):
  - E0: set expand.
  - F0: set break.
  - Any other byte: push {expand, break, byte}, then clear both flags.
  - Repeated prefixes are idempotent.
- FIFO, first-word-fall-through:
  - A pushed event is visible on ev_data with ev_valid=1 in the cycle after the push. Total latency is 2 clk cycles from the STOP fall cycle.
  - Pop: ev_valid && ev_ready. ev_ready while empty has no effect.
  - Push when full with no simultaneous pop: the event is dropped and overflow is set. The FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both are accepted and fifo_count stays at FIFO_DEPTH. The same applies at any level.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count ranges over 0..FIFO_DEPTH.
- overflow clears only on clr_flags or rst. If clr_flags and a new overflow occur in the same cycle, the set wins.

Test Plan:
- Frame for 0x1C (bits 0, 0,0,1,1,1,0,0,0, parity 0, stop 1) with ev_ready=1 -> ev_valid for 1 cycle with ev_data=10'h01C, fifo_count returns to 0, no err_*.
- Frames E0, F0, 75 -> exactly one event, ev_data=10'h375. A following frame 75 gives 10'h075 (flags cleared).
- Frame F0, then 0x1C with parity bit 1, then a good 0x1C -> err_parity pulses once and the only event is 10'h01C (break flag cleared by the error). Repeating the test with stop bit 0 -> err_frame.
- With TIMEOUT_CYC=1000, send start bit plus 4 data bits, then hold ps2_clk high for 1000+ cycles -> one err_timeout pulse. The next good frame 0x29 yields 10'h029.
- With FIFO_DEPTH=4, ev_ready=0, send codes 16,1E,26,25,2E -> fifo_count=4 and overflow=1. Draining gives 016,01E,026,025 in order; clr_flags then clears overflow. Also check a simultaneous push and pop at full keeps count at 4.
- With FILT_LEN=8, inject 3-cycle low glitches on ps2_clk between valid edges of a 0x1C frame -> no extra bits and ev_data=10'h01C. Asserting rst mid-frame -> all outputs reset, and the next full frame decodes correctly.
